digit_entry_ctrl: RTL and testbench

DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

---
 rtl/digit_entry_if.sv | 32 +++
 rtl/digit_entry_ctrl.sv | 166 ++++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_if.sv
// digit_entry_if -- bundles the digit-entry controller's data/handshake signals.
//   control : digit-valid level from the scan-code decoder (one digit per rising edge)
//   num     : decoded digit, sampled on a digit event
//   clear   : synchronous abort back to idle
//   entry   : partial BCD buffer, newest digit in [3:0]
//   count   : digits currently held in entry
//   value   : last committed BCD code
//   valid   : one-cycle pulse when value is updated
//   busy    : entry in progress
//   aborted : one-cycle pulse when an entry times out
// Modports: master drives the inputs and observes results; slave is the controller.
interface digit_entry_if;
    logic        control;
    logic [3:0]  num;
    logic        clear;
    logic [15:0] entry;
    logic [2:0]  count;
    logic [15:0] value;
    logic        valid;
    logic        busy;
    logic        aborted;

    modport master (
        output control, num, clear,
        input  entry, count, value, valid, busy, aborted
    );

    modport slave (
        input  control, num, clear,
        output entry, count, value, valid, busy, aborted
    );
endinterface

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl -- collects DIGITS BCD digits from a level-type digit-valid
// strobe and commits them as one code.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : digit_entry_if.slave (control/num/clear in; entry/count/value/valid/busy/aborted out)
// Parameters: DIGITS (1..4) digits per entry; TIMEOUT_CYCLES idle cycles before abort.
// Optional feature: define DIGIT_TIMEOUT_EN to enable the inter-digit timeout.
// Without it, ENTRY waits indefinitely and aborted is tied to 0.
module digit_entry_ctrl #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    digit_entry_if.slave  bus
);

    localparam int unsigned EntryW = 16;
    localparam int unsigned NumW   = 4;
    localparam int unsigned CountW = 3;

    // Elaboration-time parameter sanity check
    if (DIGITS < 1 || DIGITS > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("digit_entry_ctrl: DIGITS must be 1..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ctrl_q;
    logic [EntryW-1:0]   entry_q, entry_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [EntryW-1:0]   value_q, value_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                aborted_q, aborted_d;

    logic                ev_c;
    logic                digit_ok_c;
    logic                tmo_hit_c;

    // Rising edge of control is a digit event; out-of-range codes are ignored
    assign ev_c       = bus.control & ~ctrl_q;
    assign digit_ok_c = ev_c & (bus.num <= NumW'(9));

`ifdef DIGIT_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] tmo_q, tmo_d;

    assign tmo_hit_c = (tmo_q == CntW'(TIMEOUT_CYCLES - 1));

    // Counts idle ENTRY cycles; zero whenever ENTRY is entered, left, or a digit lands
    always_comb begin
        tmo_d = '0;
        if (state_q == ENTRY && state_d == ENTRY && !digit_ok_c) begin
            tmo_d = tmo_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next-state and datapath; clear beats digits, digits beat timeout
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        count_d   = count_q;
        value_d   = value_q;
        aborted_d = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            entry_d = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (digit_ok_c) begin
                        entry_d = EntryW'(bus.num);
                        count_d = CountW'(1);
                        if (DIGITS == 1) begin
                            state_d = DONE;
                            value_d = entry_d;
                        end else begin
                            state_d = ENTRY;
                        end
                    end
                end
                ENTRY: begin
                    if (digit_ok_c) begin
                        entry_d = {entry_q[EntryW-NumW-1:0], bus.num};
                        count_d = count_q + CountW'(1);
                        if (count_d == CountW'(DIGITS)) begin
                            state_d = DONE;
                            value_d = entry_d;
                        end
                    end else if (tmo_hit_c) begin
                        state_d   = IDLE;
                        entry_d   = '0;
                        count_d   = '0;
                        aborted_d = 1'b1;
                    end
                end
                DONE: begin
                    // Events arriving here are dropped
                    state_d = IDLE;
                    entry_d = '0;
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    entry_d = '0;
                    count_d = '0;
                end
            endcase
        end

        valid_d = (state_d == DONE);
        busy_d  = (state_d == ENTRY);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctrl_q    <= 1'b0;
            entry_q   <= '0;
            count_q   <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= bus.control;
            entry_q   <= entry_d;
            count_q   <= count_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.entry   = entry_q;
    assign bus.count   = count_q;
    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl -- directed self-checking bench for digit_entry_ctrl
// (DIGITS=4, TIMEOUT_CYCLES=8). Timeout checks follow DIGIT_TIMEOUT_EN.
module tb_digit_entry_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef DIGIT_TIMEOUT_EN
    localparam int HOLD = 6;
`else
    localparam int HOLD = 10;
`endif

    digit_entry_if bus_if ();

    digit_entry_ctrl #(
        .DIGITS         (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [15:0] e_entry,
                              input logic [2:0] e_count, input logic [15:0] e_value,
                              input logic e_valid, input logic e_busy, input logic e_aborted);
        chk({tag, ".entry"},   bus_if.entry,             e_entry);
        chk({tag, ".count"},   16'(bus_if.count),        16'(e_count));
        chk({tag, ".value"},   bus_if.value,             e_value);
        chk({tag, ".valid"},   16'(bus_if.valid),        16'(e_valid));
        chk({tag, ".busy"},    16'(bus_if.busy),         16'(e_busy));
        chk({tag, ".aborted"}, 16'(bus_if.aborted),      16'(e_aborted));
    endtask

    // One-cycle control pulse; outputs reflect the event after return
    task automatic press(input logic [3:0] n);
        bus_if.control = 1'b1;
        bus_if.num     = n;
        tick();
        bus_if.control = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_if.control = 1'b0;
        bus_if.num     = 4'd0;
        bus_if.clear   = 1'b0;

        // Reset state
        tick();
        tick();
        expect_all("reset", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_all("idle", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Four digits commit 1234 on the edge of the fourth
        press(4'd1);
        expect_all("d1", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick();
        press(4'd2);
        expect_all("d2", 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick();
        press(4'd3);
        expect_all("d3", 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick();
        press(4'd4);
        expect_all("commit", 16'h1234, 3'd4, 16'h1234, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("after_commit", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);

        // Held control is a single event
        bus_if.control = 1'b1;
        bus_if.num     = 4'd7;
        tick();
        expect_all("hold1", 16'h0007, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        repeat (HOLD - 1) tick();
        expect_all("hold_end", 16'h0007, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        bus_if.control = 1'b0;
        tick();
        expect_all("release", 16'h0007, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
        expect_all("clear_idle", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);

        // Clear wins over a simultaneous digit event
        press(4'd5);
        tick();
        press(4'd6);
        expect_all("d56", 16'h0056, 3'd2, 16'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        bus_if.control = 1'b1;
        bus_if.num     = 4'd8;
        bus_if.clear   = 1'b1;
        tick();
        bus_if.control = 1'b0;
        bus_if.clear   = 1'b0;
        expect_all("clear_wins", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
        tick();
        expect_all("clear_after", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);

        // Out-of-range codes ignored in IDLE and ENTRY
        press(4'hA);
        expect_all("bad_idle", 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
        tick();
        press(4'd3);
        expect_all("after_bad", 16'h0003, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        press(4'hF);
        expect_all("bad_entry", 16'h0003, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;

        // Reset mid-entry discards it; control high at release is one event
        press(4'd9);
        expect_all("pre_rst", 16'h0009, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0);
        rst_n          = 1'b0;
        bus_if.control = 1'b1;
        bus_if.num     = 4'd2;
        tick();
        expect_all("rst_entry", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_all("rst_release_event", 16'h0002, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
        bus_if.control = 1'b0;
        tick();
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
        expect_all("rst_cleared", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Inter-digit timeout behaviour
        press(4'd1);
        expect_all("tmo_digit", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
`ifdef DIGIT_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("tmo_wait.aborted", 16'(bus_if.aborted), 16'd0);
            chk("tmo_wait.busy",    16'(bus_if.busy),    16'd1);
        end
        tick();
        expect_all("timeout", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        chk("timeout_pulse_end", 16'(bus_if.aborted), 16'd0);

        // Digit exactly at terminal count wins and restarts the timer
        press(4'd1);
        repeat (7) tick();
        press(4'd5);
        expect_all("tc_digit", 16'h0015, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("tc_wait.aborted", 16'(bus_if.aborted), 16'd0);
            chk("tc_wait.count",   16'(bus_if.count),   16'd2);
        end
        tick();
        expect_all("tc_timeout", 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
`else
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("no_tmo.aborted", 16'(bus_if.aborted), 16'd0);
            chk("no_tmo.busy",    16'(bus_if.busy),    16'd1);
        end
        expect_all("no_tmo_end", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
        bus_if.clear = 1'b1;
        tick();
        bus_if.clear = 1'b0;
`endif

        // Second commit updates value, which then holds
        press(4'd9);
        tick();
        press(4'd8);
        tick();
        press(4'd7);
        tick();
        press(4'd6);
        expect_all("commit2", 16'h9876, 3'd4, 16'h9876, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expect_all("value_hold", 16'h0000, 3'd0, 16'h9876, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
